// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: memory-wait FSM, load-use and branch flush/stall control.
// Optional stall-cycle performance counter enabled by PIPE_CTRL_PERF_EN.
module pipe_ctrl (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [4:0]  id_rs1_addr_i,
    input  logic [4:0]  id_rs2_addr_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_write_rd_i,
    input  logic        ex_wb_use_mem_i,
    input  logic        ex_new_pc_en_i,
    input  logic        mem_req_i,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_stall_o,
    output logic        mem_wb_flush_o,
    output logic [31:0] stall_cycles_o
);

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WAIT_GNT    = 2'd1,
        WAIT_RVALID = 2'd2
    } mem_state_e;

    mem_state_e state_q, state_d;
    logic       mem_stall;
    logic       load_use;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Progress depends only on gnt/rvalid once a request has started.
    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    mem_stall = 1'b1;
                    state_d   = mem_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                mem_stall = 1'b1;
                if (mem_gnt_i) begin
                    state_d = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (mem_rvalid_i) begin
                    state_d = IDLE;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // rs usage is not decoded, so a non-reading instruction may stall needlessly.
    assign load_use = ex_wb_use_mem_i & ex_write_rd_i & (ex_rd_addr_i != 5'd0) &
                      ((ex_rd_addr_i == id_rs1_addr_i) | (ex_rd_addr_i == id_rs2_addr_i));

    // Memory stall freezes everything upstream, so branch and load-use wait behind it.
    always_comb begin
        if_id_stall_o  = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_stall_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_stall_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        if (mem_stall) begin
            if_id_stall_o  = 1'b1;
            id_ex_stall_o  = 1'b1;
            ex_mem_stall_o = 1'b1;
            mem_wb_flush_o = 1'b1;
        end else if (ex_new_pc_en_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (load_use) begin
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Free-running wrap-around count of front-end stall cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (if_id_stall_o) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cycles_o = stall_cnt_q;
`else
    assign stall_cycles_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected control/counter values queued per driven cycle.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ctrl order: {if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] MEMS = 6'b101011;
    localparam logic [5:0] BR   = 6'b010100;
    localparam logic [5:0] LU   = 6'b100100;

    typedef struct packed {
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       wr;
        logic       ld;
        logic       br;
        logic       req;
        logic       gnt;
        logic       rvalid;
    } stim_t;

    logic        clk;
    logic        rstn;
    logic [4:0]  rs1, rs2, rd;
    logic        wr, ld, br, req, gnt, rvalid;
    logic        if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush;
    logic [31:0] stall_cycles;
    logic [5:0]  ctrl_act;

    int          total;
    int          bad;
    logic [31:0] exp_cnt;
    logic [37:0] sb[$];

    assign ctrl_act = {if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush};

    pipe_ctrl dut (
        .clk_i           (clk),
        .rstn_i          (rstn),
        .id_rs1_addr_i   (rs1),
        .id_rs2_addr_i   (rs2),
        .ex_rd_addr_i    (rd),
        .ex_write_rd_i   (wr),
        .ex_wb_use_mem_i (ld),
        .ex_new_pc_en_i  (br),
        .mem_req_i       (req),
        .mem_gnt_i       (gnt),
        .mem_rvalid_i    (rvalid),
        .if_id_stall_o   (if_id_stall),
        .if_id_flush_o   (if_id_flush),
        .id_ex_stall_o   (id_ex_stall),
        .id_ex_flush_o   (id_ex_flush),
        .ex_mem_stall_o  (ex_mem_stall),
        .mem_wb_flush_o  (mem_wb_flush),
        .stall_cycles_o  (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t mk(input logic [4:0] f_rd, input logic [4:0] f_rs1, input logic [4:0] f_rs2,
                                 input logic f_wr, input logic f_ld, input logic f_br,
                                 input logic f_req, input logic f_gnt, input logic f_rv);
        stim_t s;
        s.rd = f_rd; s.rs1 = f_rs1; s.rs2 = f_rs2;
        s.wr = f_wr; s.ld = f_ld; s.br = f_br;
        s.req = f_req; s.gnt = f_gnt; s.rvalid = f_rv;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rd = s.rd; rs1 = s.rs1; rs2 = s.rs2;
        wr = s.wr; ld = s.ld; br = s.br;
        req = s.req; gnt = s.gnt; rvalid = s.rvalid;
    endtask

    // Queue the expected outputs for the cycle now being driven and advance the counter model.
    task automatic expect_cycle(input logic [5:0] c);
        sb.push_back({c, exp_cnt});
        if (PERF && c[5]) exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic test_reset;
        logic [37:0] e;
        rstn = 1'b0;
        apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        exp_cnt = 32'd0;
        #2;
        expect_cycle(NONE);
        e = sb.pop_front();
        total++;
        if ({ctrl_act, stall_cycles} !== e) begin
            bad++;
            $display("FAIL reset_async: got=%b/%h exp=%b/%h", ctrl_act, stall_cycles, e[37:32], e[31:0]);
        end
        repeat (3) @(posedge clk);
        #1;
        expect_cycle(NONE);
        e = sb.pop_front();
        total++;
        if ({ctrl_act, stall_cycles} !== e) begin
            bad++;
            $display("FAIL reset_clocked: got=%b/%h exp=%b/%h", ctrl_act, stall_cycles, e[37:32], e[31:0]);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use;
        stim_t       st[$];
        logic [5:0]  ex[$];
        logic [37:0] e;
        st.push_back(mk(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(LU);
        st.push_back(mk(5'd7, 5'd5, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(NONE);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(NONE);
        st.push_back(mk(5'd12, 5'd12, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(LU);
        st.push_back(mk(5'd12, 5'd12, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(NONE);
        st.push_back(mk(5'd12, 5'd4, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(NONE);
        st.push_back(mk(5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(LU);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            expect_cycle(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if (ctrl_act !== e[37:32]) begin
                bad++;
                $display("FAIL load_use[%0d] ctrl: got=%b exp=%b", i, ctrl_act, e[37:32]);
            end
            total++;
            if (stall_cycles !== e[31:0]) begin
                bad++;
                $display("FAIL load_use[%0d] cnt: got=%h exp=%h", i, stall_cycles, e[31:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_branch;
        stim_t       st[$];
        logic [5:0]  ex[$];
        logic [37:0] e;
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(BR);
        st.push_back(mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(BR);
        st.push_back(mk(5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(LU);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(NONE);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            expect_cycle(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({ctrl_act, stall_cycles} !== e) begin
                bad++;
                $display("FAIL branch[%0d]: got=%b/%h exp=%b/%h", i, ctrl_act, stall_cycles, e[37:32], e[31:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // gnt two cycles late (rvalid ignored while waiting), req dropped, branch/load-use masked.
    task automatic test_mem_wait;
        stim_t       st[$];
        logic [5:0]  ex[$];
        logic [37:0] e;
        logic [31:0] base;
        base = exp_cnt;
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)); ex.push_back(MEMS);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1)); ex.push_back(MEMS);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)); ex.push_back(MEMS);
        st.push_back(mk(5'd6, 5'd6, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0)); ex.push_back(MEMS);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(MEMS);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); ex.push_back(NONE);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(NONE);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            expect_cycle(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({ctrl_act, stall_cycles} !== e) begin
                bad++;
                $display("FAIL mem_wait[%0d]: got=%b/%h exp=%b/%h", i, ctrl_act, stall_cycles, e[37:32], e[31:0]);
            end
            @(posedge clk);
            #1;
        end
        total++;
        if (stall_cycles - base !== (PERF ? 32'd5 : 32'd0)) begin
            bad++;
            $display("FAIL mem_wait_count: got=%0d exp=%0d", stall_cycles - base, PERF ? 5 : 0);
        end
    endtask

    // Fast path then an access issued while the previous rvalid completes.
    task automatic test_back_to_back;
        stim_t       st[$];
        logic [5:0]  ex[$];
        logic [37:0] e;
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); ex.push_back(MEMS);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); ex.push_back(NONE);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); ex.push_back(MEMS);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1)); ex.push_back(NONE);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)); ex.push_back(MEMS);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1)); ex.push_back(NONE);
        st.push_back(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); ex.push_back(NONE);
        for (int i = 0; i < st.size(); i++) begin
            apply(st[i]);
            expect_cycle(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({ctrl_act, stall_cycles} !== e) begin
                bad++;
                $display("FAIL back_to_back[%0d]: got=%b/%h exp=%b/%h", i, ctrl_act, stall_cycles, e[37:32], e[31:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid;
        logic [37:0] e;
        apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
        expect_cycle(MEMS);
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if ({ctrl_act, stall_cycles} !== e) begin
            bad++;
            $display("FAIL reset_mid_enter: got=%b/%h exp=%b/%h", ctrl_act, stall_cycles, e[37:32], e[31:0]);
        end
        @(posedge clk);
        #1;
        // Now parked in WAIT_RVALID; reset between clock edges.
        apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        rstn = 1'b0;
        exp_cnt = 32'd0;
        #2;
        expect_cycle(NONE);
        e = sb.pop_front();
        total++;
        if ({ctrl_act, stall_cycles} !== e) begin
            bad++;
            $display("FAIL reset_mid_async: got=%b/%h exp=%b/%h", ctrl_act, stall_cycles, e[37:32], e[31:0]);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        // Still in WAIT_RVALID would stall here with rvalid low.
        expect_cycle(NONE);
        @(negedge clk);
        e = sb.pop_front();
        total++;
        if ({ctrl_act, stall_cycles} !== e) begin
            bad++;
            $display("FAIL reset_mid_idle: got=%b/%h exp=%b/%h", ctrl_act, stall_cycles, e[37:32], e[31:0]);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_CTRL_PERF_EN
    task automatic test_counter_wrap;
        logic [5:0]  ex[$];
        logic [37:0] e;
        force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.stall_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        ex.push_back(MEMS); ex.push_back(NONE); ex.push_back(NONE);
        for (int i = 0; i < ex.size(); i++) begin
            if (i == 0) apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
            else if (i == 1) apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
            else apply(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
            expect_cycle(ex[i]);
            @(negedge clk);
            e = sb.pop_front();
            total++;
            if ({ctrl_act, stall_cycles} !== e) begin
                bad++;
                $display("FAIL counter_wrap[%0d]: got=%b/%h exp=%b/%h", i, ctrl_act, stall_cycles, e[37:32], e[31:0]);
            end
            @(posedge clk);
            #1;
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_back_to_back();
        test_reset_mid();
`ifdef PIPE_CTRL_PERF_EN
        test_counter_wrap();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have a single clock domain, and reset SHALL be asynchronous and active-low: clk_i input 1, rising-edge clock; rstn_i input 1, async active-low reset.
REQ-002 id_rs1_addr_i input 5: rs1 address of the instruction currently in ID.
REQ-003 id_rs2_addr_i input 5: rs2 address of the instruction currently in ID.
REQ-004 ex_rd_addr_i input 5: rd address of the instruction in EX.
REQ-005 ex_write_rd_i input 1: the instruction in EX writes rd.
REQ-006 ex_wb_use_mem_i input 1: the instruction in EX is a load.
REQ-007 ex_new_pc_en_i input 1: EX resolved a taken branch or jump this cycle.
REQ-008 mem_req_i input 1: the MEM stage holds a load/store.
REQ-009 mem_gnt_i input 1: the data bus accepted the request.
REQ-010 mem_rvalid_i input 1: the data bus completed the access.
REQ-011 if_id_stall_o, if_id_flush_o, id_ex_stall_o, id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o outputs 1 each: per-register hold/zero controls.
REQ-012 stall_cycles_o output 32: performance counter of stalled cycles.

Function
REQ-013 Mem FSM states SHALL be IDLE, WAIT_GNT and WAIT_RVALID.
REQ-014 FSM transitions SHALL be: IDLE & mem_req_i & mem_gnt_i -> WAIT_RVALID; IDLE & mem_req_i & !mem_gnt_i -> WAIT_GNT; WAIT_GNT & mem_gnt_i -> WAIT_RVALID; WAIT_RVALID & mem_rvalid_i -> IDLE; otherwise the FSM holds its state.
REQ-015 In WAIT_GNT, mem_rvalid_i SHALL be ignored; if mem_gnt_i and mem_rvalid_i are high together, only mem_gnt_i is honoured.
REQ-016 mem_stall SHALL be (IDLE & mem_req_i) | WAIT_GNT | (WAIT_RVALID & !mem_rvalid_i), giving a minimum of one stall cycle per access.
REQ-017 mem_req_i deasserting mid-transaction SHALL NOT abort the FSM; progress depends only on gnt and rvalid.
REQ-018 load_use SHALL be ex_wb_use_mem_i & ex_write_rd_i & (ex_rd_addr_i != 0) & (ex_rd_addr_i == id_rs1_addr_i | ex_rd_addr_i == id_rs2_addr_i).
REQ-019 Because rs usage is not decoded, load_use MAY produce false stalls; this SHALL be accepted behaviour.
REQ-020 Priority 1, mem_stall: if_id_stall_o = id_ex_stall_o = ex_mem_stall_o = 1 and mem_wb_flush_o = 1; all other outputs 0; branch and load-use are deferred, since their inputs are frozen.
REQ-021 Priority 2, ex_new_pc_en_i: if_id_flush_o = id_ex_flush_o = 1; load_use is ignored.
REQ-022 Priority 3, load_use: if_id_stall_o = 1 and id_ex_flush_o = 1 (one bubble); a second stall SHALL NOT occur, because the load leaves EX.
REQ-023 With no condition active, all control outputs SHALL be 0.
REQ-024 Control outputs SHALL be combinational from FSM state and inputs with zero cycle latency, and SHALL be glitch-tolerant (sampled only at clk_i edges).

Reset
REQ-025 rstn_i low SHALL force the FSM to IDLE and stall_cycles_o to 0 immediately, including mid-transaction.
REQ-026 With rstn_i low and all inputs 0, every control output SHALL be 0.
REQ-027 The first edge after reset release SHALL evaluate from IDLE.

Configuration
REQ-028 Macro PIPE_CTRL_PERF_EN defined: stall_cycles_o SHALL increment by 1 on every cycle in which if_id_stall_o = 1, wrapping from 0xFFFFFFFF to 0.
REQ-029 PIPE_CTRL_PERF_EN undefined: the counter SHALL NOT be instantiated, and stall_cycles_o SHALL be tied to 0 with the port retained.

Verification
REQ-030 Load-use: EX load rd = 5 with ID rs2 = 5 -> exactly one cycle of if_id_stall_o = 1 and id_ex_flush_o = 1; the same case with rd = 0 -> no stall.
REQ-031 Branch and load-use together: ex_new_pc_en_i = 1 and load_use = 1 -> if_id_flush_o = id_ex_flush_o = 1 and if_id_stall_o = 0.
REQ-032 Memory wait: mem_req_i with gnt after 2 cycles and rvalid 3 cycles later -> states IDLE, WAIT_GNT, WAIT_GNT, WAIT_RVALID x3, IDLE; ex_mem_stall_o high for 5 cycles, and with PIPE_CTRL_PERF_EN defined stall_cycles_o = 5.
REQ-033 Fast path: mem_req_i with gnt same cycle and rvalid next cycle -> exactly 1 stall cycle.
REQ-034 Reset mid-op: rstn_i low while in WAIT_RVALID -> FSM returns to IDLE, all outputs 0 and stall_cycles_o = 0 without waiting for a clock edge.
REQ-035 Counter wrap: with PIPE_CTRL_PERF_EN defined and the counter forced to 0xFFFFFFFF, one stall cycle -> stall_cycles_o = 0.
